reg_status_file: RTL and testbench
==================================

Name: reg_status_file

Overview:
- Parametrised architectural register file plus rename-tag (dependency) table for the Tomasulo issue stage.
- Successor to the single-port, single-CDB register file.
- Adds: N source read ports, M write-back channels, correct tag ownership on write-back, same-cycle CDB bypass, flush on mispredict, and a registered pending-dependency count.
- Sits between decoder/issue logic and the RS/LSB; fed by the CDB and RS write-back buses.

Parameters:
XLEN, 32, data width of each register
TAG_W, 4, rename tag width; tag 0 is reserved as None (no dependency)
NUM_RD, 2, number of source read ports
NUM_WB, 2, number of write-back channels (CDB, RS submit, ...)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous reset, active-low
rdy_in  input  1  global ready; low = pause, state held
flush_in  input  1  mispredict flush: clear all dependencies
issue_valid  input  1  instruction issued this cycle
issue_rd  input  5  destination register of issued instruction
issue_tag  input  TAG_W  rename tag assigned to issue_rd
rd_addr  input  NUM_RD*5  source register indices, port p at [5p+4:5p]
rd_val  output  NUM_RD*XLEN  source values; 0 when dependency outstanding
rd_tag  output  NUM_RD*TAG_W  source dependency tags; 0 = ready
wb_valid  input  NUM_WB  per-channel write-back valid
wb_tag  input  NUM_WB*TAG_W  per-channel producing tag
wb_val  input  NUM_WB*XLEN  per-channel result value
pending_cnt  output  6  registered count of registers with nonzero tag

Behaviour:
- Reset (rst_in==0 at clock edge, priority over rdy_in and flush_in):
  - all 31 values <= 0; all tags <= 0; pending_cnt <= 0.
- rdy_in==0: no state change. Read ports remain combinational on held state.
- x0: value and tag are constant 0. Issue to rd=0 is ignored.
- Issue with issue_tag==0 is ignored.
- Read port p (combinational, zero latency):
  - t = tag[rd_addr_p].
  - If t==0: rd_tag_p=0, rd_val_p=value.
  - Else: rd_tag_p=t, rd_val_p=0 (see the optional bypass feature).
  - Reads see pre-update state: an issue in the same cycle does not affect its own source reads.
- Write-back (per clock, rdy_in==1), for each channel k with wb_valid[k] and wb_tag_k!=0:
  - Every register i>=1 with tag[i]==wb_tag_k gets value[i] <= wb_val_k and tag[i] <= 0.
  - Match is against the current tag only. A register renamed to a newer tag is never cleared by an older tag.
  - Two channels with the same tag in one cycle: lowest channel index wins the value.
- Issue vs write-back on the same register, same cycle:
  - value takes the write-back data if the old tag matched.
  - tag takes issue_tag; issue wins the tag.
- Flush (flush_in==1, rdy_in==1):
  - all tags <= 0 next cycle.
  - Same-cycle write-backs still update values, but tags end 0.
  - Same-cycle issue is dropped.
- pending_cnt: popcount of (tag!=0) over the next-state table, registered. Updated every active cycle; range 0..31.
- Pure bookkeeping: no handshake back-pressure, no reordering.

Optional Feature:
- Macro REGFILE_CDB_BYPASS_EN.
- Defined:
  - When read-port tag t!=0 matches a valid wb channel tag this cycle, the port returns rd_tag_p=0 and rd_val_p=that wb_val (lowest matching channel).
  - Combinational path from wb_* to rd_* exists.
- Undefined:
  - No forwarding; the consumer sees the tag and must snoop the CDB itself.
  - rd_* depends only on registered state and rd_addr.

Test Plan:
- Reset, then read x5 on port 0 -> rd_val=0, rd_tag=0, pending_cnt=0. Issue rd=5 tag=3 -> next cycle rd_tag=3, rd_val=0, pending_cnt=1.
- x5 tag=3; wb ch1 tag=3 val=0xDEADBEEF -> next cycle x5 val=0xDEADBEEF, tag=0, pending_cnt=0.
- x5 tag=3, then issue rd=5 tag=7 while wb tag=3 val=0x11 -> x5 tag=7, val=0x11. A later wb tag=3 val=0x22 leaves x5 unchanged.
- x1 tag=2, x2 tag=4, flush_in=1 with issue rd=3 tag=5 -> all tags 0, x3 not renamed, pending_cnt=0, values preserved.
- rdy_in=0 with issue rd=6 tag=1 and wb tag=2 -> no change. issue rd=0 tag=9 -> x0 stays 0/0.
- REGFILE_CDB_BYPASS_EN defined, x4 tag=6, wb ch0 tag=6 val=0x55 -> same cycle rd_tag=0, rd_val=0x55. Undefined -> rd_tag=6, rd_val=0.

Source files
------------

// File: rtl/reg_status_file.sv
// reg_status_file
//   Architectural register file plus rename-tag (dependency) table for the
//   Tomasulo issue stage. Each of x1..x31 holds a value and the tag of the
//   in-flight producer (0 = ready). x0 is hard-wired to value 0, tag 0.
//
// Ports
//   clk_in, rst_in      clock (rising edge), synchronous active-low reset
//   rdy_in              global ready; low freezes all state
//   flush_in            mispredict flush: every tag cleared next cycle
//   issue_valid/rd/tag  rename issue_rd to issue_tag (tag 0 or rd 0 ignored)
//   rd_addr             NUM_RD packed 5-bit source indices
//   rd_val, rd_tag      per-port combinational value/tag (val 0 while pending)
//   wb_valid/tag/val    NUM_WB write-back channels; lowest index wins on ties
//   pending_cnt         registered count of registers with a nonzero tag
//
// Configuration
//   REGFILE_CDB_BYPASS_EN  when defined, a read whose tag matches a valid
//                          write-back this cycle returns the write-back value
//                          with tag 0 (combinational wb_* -> rd_* path).
//
// There are no handshakes: every input is sampled on each active clock edge
// and no back-pressure is ever applied.

module reg_status_file #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_WB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic [NUM_RD*5-1:0]      rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_val,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*XLEN-1:0]   wb_val,
  output logic [5:0]               pending_cnt
);

  // Entry 0 is never written, so x0 reads back as 0/0 without special cases.
  logic [XLEN-1:0]  r_val [32];
  logic [TAG_W-1:0] r_tag [32];
  logic [5:0]       r_cnt;

  logic [XLEN-1:0]  w_val_nxt [32];
  logic [TAG_W-1:0] w_tag_nxt [32];
  logic [5:0]       w_cnt;

  // Next-state table. Channels are scanned from highest to lowest index so
  // the lowest matching channel is the last writer and wins the value.
  // Matching uses the current tag only, so a register already renamed to a
  // newer tag ignores write-backs of its older producer.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_val_nxt[i] = r_val[i];
      w_tag_nxt[i] = r_tag[i];
    end
    for (int i = 1; i < 32; i++) begin
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] != '0) &&
            (r_tag[i] == wb_tag[k*TAG_W +: TAG_W])) begin
          w_val_nxt[i] = wb_val[k*XLEN +: XLEN];
          w_tag_nxt[i] = '0;
        end
      end
      // Flush drops any same-cycle issue; otherwise issue overrides the tag
      // cleared by a write-back (the value still takes the write-back data).
      if (flush_in) begin
        w_tag_nxt[i] = '0;
      end else if (issue_valid && (issue_tag != '0) && (issue_rd == 5'(i))) begin
        w_tag_nxt[i] = issue_tag;
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 1; i < 32; i++) begin
      if (w_tag_nxt[i] != '0) w_cnt = w_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_cnt <= '0;
    end else if (rdy_in) begin
      r_val <= w_val_nxt;
      r_tag <= w_tag_nxt;
      r_cnt <= w_cnt;
    end
  end

  assign pending_cnt = r_cnt;

  // Read ports observe the pre-update state.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [4:0]       w_addr;
    logic [TAG_W-1:0] w_cur_tag;
    logic [TAG_W-1:0] w_rd_tag;
    logic [XLEN-1:0]  w_rd_val;

    assign w_addr    = rd_addr[p*5 +: 5];
    assign w_cur_tag = r_tag[w_addr];

    always_comb begin
      w_rd_tag = w_cur_tag;
      w_rd_val = (w_cur_tag == '0) ? r_val[w_addr] : '0;
`ifdef REGFILE_CDB_BYPASS_EN
      if (w_cur_tag != '0) begin
        for (int k = NUM_WB - 1; k >= 0; k--) begin
          if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == w_cur_tag)) begin
            w_rd_tag = '0;
            w_rd_val = wb_val[k*XLEN +: XLEN];
          end
        end
      end
`endif
    end

    assign rd_tag[p*TAG_W +: TAG_W] = w_rd_tag;
    assign rd_val[p*XLEN +: XLEN]   = w_rd_val;
  end

endmodule

// File: tb/tb_reg_status_file.sv
module tb_reg_status_file;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 4;
  localparam int NUM_RD = 2;
  localparam int NUM_WB = 2;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     rdy_in;
  logic                     flush_in;
  logic                     issue_valid;
  logic [4:0]               issue_rd;
  logic [TAG_W-1:0]         issue_tag;
  logic [NUM_RD*5-1:0]      rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_val;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*XLEN-1:0]   wb_val;
  logic [5:0]               pending_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  reg_status_file #(
    .XLEN(XLEN), .TAG_W(TAG_W), .NUM_RD(NUM_RD), .NUM_WB(NUM_WB)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rd_addr(rd_addr), .rd_val(rd_val), .rd_tag(rd_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .pending_cnt(pending_cnt)
  );

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change 1ns after the rising edge; outputs are checked from there.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    flush_in    = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_tag   = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_val      = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [TAG_W-1:0] tag);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_tag   = tag;
  endtask

  task automatic wb(input int ch, input logic [TAG_W-1:0] tag, input logic [31:0] val);
    wb_valid[ch]               = 1'b1;
    wb_tag[ch*TAG_W +: TAG_W]  = tag;
    wb_val[ch*XLEN +: XLEN]    = val;
  endtask

  task automatic read(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic check_port(input string name, input int p,
                            input logic [31:0] exp_val, input logic [TAG_W-1:0] exp_tag);
    check({name, "_val"}, rd_val[p*XLEN +: XLEN], exp_val);
    check({name, "_tag"}, 32'(rd_tag[p*TAG_W +: TAG_W]), 32'(exp_tag));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rd_addr = '0;
    idle();
    tick(); tick();
    rst_in = 1'b1;

    // Reset state
    read(5'd5, 5'd0);
    check_port("rst_x5", 0, 32'h0, 4'd0);
    check_port("rst_x0", 1, 32'h0, 4'd0);
    check("rst_cnt", 32'(pending_cnt), 32'd0);

    // Issue x5 tag 3
    issue(5'd5, 4'd3); tick(); idle();
    read(5'd5, 5'd0);
    check_port("iss_x5", 0, 32'h0, 4'd3);
    check("iss_cnt", 32'(pending_cnt), 32'd1);

    // Write-back on channel 1 resolves x5
    wb(1, 4'd3, 32'hDEADBEEF);
    read(5'd5, 5'd0);
`ifdef REGFILE_CDB_BYPASS_EN
    check_port("wb_pre_x5", 0, 32'hDEADBEEF, 4'd0);
`else
    check_port("wb_pre_x5", 0, 32'h0, 4'd3);
`endif
    tick(); idle();
    read(5'd5, 5'd0);
    check_port("wb_x5", 0, 32'hDEADBEEF, 4'd0);
    check("wb_cnt", 32'(pending_cnt), 32'd0);

    // Rename while old producer writes back: issue wins tag, wb wins value
    issue(5'd5, 4'd3); tick(); idle();
    issue(5'd5, 4'd7); wb(0, 4'd3, 32'h11); tick(); idle();
    read(5'd5, 5'd0);
    check_port("ren_x5", 0, 32'h0, 4'd7);
    check("ren_cnt", 32'(pending_cnt), 32'd1);
    // Stale tag 3 must not clear or overwrite x5
    wb(0, 4'd3, 32'h22); tick(); idle();
    read(5'd5, 5'd0);
    check_port("stale_x5", 0, 32'h0, 4'd7);
    check("stale_cnt", 32'(pending_cnt), 32'd1);
    // Flush exposes the stored value, which must be 0x11
    flush_in = 1'b1; tick(); idle();
    read(5'd5, 5'd0);
    check_port("fl1_x5", 0, 32'h11, 4'd0);
    check("fl1_cnt", 32'(pending_cnt), 32'd0);

    // Two channels, same tag: channel 0 wins the value
    issue(5'd7, 4'd2); tick(); idle();
    wb(0, 4'd2, 32'hAAAA); wb(1, 4'd2, 32'hBBBB); tick(); idle();
    read(5'd7, 5'd0);
    check_port("tie_x7", 0, 32'hAAAA, 4'd0);
    check("tie_cnt", 32'(pending_cnt), 32'd0);

    // One write-back resolves every register holding the tag
    issue(5'd8, 4'd4); tick(); idle();
    issue(5'd9, 4'd4); tick(); idle();
    check("multi_pre_cnt", 32'(pending_cnt), 32'd2);
    wb(1, 4'd4, 32'h44); tick(); idle();
    read(5'd8, 5'd9);
    check_port("multi_x8", 0, 32'h44, 4'd0);
    check_port("multi_x9", 1, 32'h44, 4'd0);
    check("multi_cnt", 32'(pending_cnt), 32'd0);

    // Flush with same-cycle issue (dropped) and write-back (value kept)
    issue(5'd1, 4'd2); tick(); idle();
    issue(5'd2, 4'd4); tick(); idle();
    check("fl2_pre_cnt", 32'(pending_cnt), 32'd2);
    flush_in = 1'b1; issue(5'd3, 4'd5); wb(0, 4'd2, 32'h77); tick(); idle();
    read(5'd1, 5'd2);
    check_port("fl2_x1", 0, 32'h77, 4'd0);
    check_port("fl2_x2", 1, 32'h0, 4'd0);
    read(5'd3, 5'd5);
    check_port("fl2_x3", 0, 32'h0, 4'd0);
    check_port("fl2_x5", 1, 32'h11, 4'd0);
    check("fl2_cnt", 32'(pending_cnt), 32'd0);

    // rdy_in low freezes everything
    issue(5'd11, 4'd2); tick(); idle();
    rdy_in = 1'b0; issue(5'd6, 4'd1); wb(0, 4'd2, 32'h99); tick(); idle();
    rdy_in = 1'b1;
    read(5'd6, 5'd11);
    check_port("hold_x6", 0, 32'h0, 4'd0);
    check_port("hold_x11", 1, 32'h0, 4'd2);
    check("hold_cnt", 32'(pending_cnt), 32'd1);

    // Issue to x0 and issue with tag 0 are ignored
    issue(5'd0, 4'd9); tick(); idle();
    issue(5'd12, 4'd0); tick(); idle();
    read(5'd0, 5'd12);
    check_port("x0", 0, 32'h0, 4'd0);
    check_port("tag0_x12", 1, 32'h0, 4'd0);
    check("x0_cnt", 32'(pending_cnt), 32'd1);

    // Same-cycle read of a register whose producer is on the CDB
    issue(5'd4, 4'd6); tick(); idle();
    wb(0, 4'd6, 32'h55);
    read(5'd0, 5'd4);
`ifdef REGFILE_CDB_BYPASS_EN
    check_port("byp_x4", 1, 32'h55, 4'd0);
`else
    check_port("byp_x4", 1, 32'h0, 4'd6);
`endif
    tick(); idle();
    read(5'd0, 5'd4);
    check_port("byp_after_x4", 1, 32'h55, 4'd0);
    check("byp_cnt", 32'(pending_cnt), 32'd1);

    // Reset has priority over rdy_in low and flush
    rst_in = 1'b0; rdy_in = 1'b0; issue(5'd13, 4'd3); tick(); idle();
    rst_in = 1'b1; rdy_in = 1'b1;
    read(5'd11, 5'd5);
    check_port("rst2_x11", 0, 32'h0, 4'd0);
    check_port("rst2_x5", 1, 32'h0, 4'd0);
    check("rst2_cnt", 32'(pending_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
